mc_sequencer: RTL and testbench

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/mem_wait_timer.sv | 36 +++
 rtl/mc_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared sequencer definitions: FSM states, opcode classes, opcodes,
// ALU function codes, mem_size and pc_src encodings, opcode classifier.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CL_R,
    CL_IMM,
    CL_LOAD,
    CL_STORE,
    CL_BR,
    CL_JMP,
    CL_BAD
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_BEQ  = 6'h30;
  localparam logic [5:0] ALU_BNE  = 6'h31;

  localparam logic [1:0] MSZ_BYTE = 2'b00;
  localparam logic [1:0] MSZ_WORD = 2'b11;

  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;

  function automatic cls_e op_class(input logic [5:0] op);
    case (op)
      OP_RTYPE:          return CL_R;
      OP_ADDI, OP_ADDIU: return CL_IMM;
      OP_LB, OP_LW:      return CL_LOAD;
      OP_SB, OP_SW:      return CL_STORE;
      OP_BEQ, OP_BNE:    return CL_BR;
      OP_J:              return CL_JMP;
      default:           return CL_BAD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts not-ready cycles, clears on state change.
// Ports: clk, reset, count, clear in; expire out (last allowed cycle).
module mem_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic count,
  input  logic clear,
  output logic expire
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the LIMIT-th consecutive not-ready cycle.
  assign expire = count && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle MIPS control sequencer (FETCH/DECODE/EXECUTE/MEM/WB/TRAP).
// Ins: clk, reset, opcode, funct, imem/dmem_ready, alu_branch/jump.
// Outs: datapath enables, mem_size, alu_func, pc_src, trap, retired.
// Optional: SEQ_PERF_CNT_EN enables the retired-instruction counter.
module mc_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             alu_branch,
  input  logic             alu_jump,
  output logic             pc_we,
  output logic             ir_we,
  output logic             reg_write_enable,
  output logic             mem_read_enable,
  output logic             mem_write_enable,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic [1:0]       mem_size,
  output logic [5:0]       alu_func,
  output logic [1:0]       pc_src,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  state_e     state_q;
  state_e     state_d;
  logic [5:0] op_q;
  logic [5:0] op_d;
  logic [5:0] fn_q;
  logic [5:0] fn_d;
  cls_e       cls;
  logic       byte_op;
  logic       wait_cnt;
  logic       wait_clr;
  logic       wait_exp;
  logic       retire;
  logic       unused_jump;

  // Jumps are recognised from the opcode alone.
  assign unused_jump = alu_jump;

  assign cls     = op_class(op_q);
  assign byte_op = (op_q == OP_LB) || (op_q == OP_SB);

  assign wait_cnt = (state_q == ST_FETCH && !imem_ready) ||
                    (state_q == ST_MEM && !dmem_ready);
  assign wait_clr = (state_d != state_q);

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .count (wait_cnt),
    .clear (wait_clr),
    .expire(wait_exp)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    retire  = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_exp) begin
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: begin
        op_d = opcode;
        fn_d = funct;
        if (op_class(opcode) == CL_BAD) begin
          state_d = ST_TRAP;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        unique case (cls)
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          CL_R, CL_IMM:      state_d = ST_WB;
          CL_BR, CL_JMP: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          default:           state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) begin
          if (cls == CL_LOAD) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_exp) begin
          state_d = ST_TRAP;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
    end
  end

  always_comb begin
    pc_we            = 1'b0;
    ir_we            = 1'b0;
    reg_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    alu_src          = 1'b0;
    mem_to_reg       = 1'b0;
    reg_dst          = 1'b0;
    mem_size         = MSZ_WORD;
    alu_func         = ALU_ADD;
    pc_src           = PC_SEQ;
    trap             = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        // Reset holds the FSM in FETCH; keep the strobes quiet meanwhile.
        ir_we = imem_ready && !reset;
        pc_we = imem_ready && !reset;
      end
      ST_DECODE: begin
      end
      ST_EXECUTE: begin
        unique case (cls)
          CL_R: alu_func = fn_q;
          CL_IMM, CL_LOAD, CL_STORE: alu_src = 1'b1;
          CL_BR: begin
            alu_func = (op_q == OP_BEQ) ? ALU_BEQ : ALU_BNE;
            pc_we    = alu_branch;
            pc_src   = PC_BR;
          end
          CL_JMP: begin
            pc_we  = 1'b1;
            pc_src = PC_JMP;
          end
          default: begin
          end
        endcase
      end
      ST_MEM: begin
        mem_read_enable  = (cls == CL_LOAD);
        mem_write_enable = (cls == CL_STORE);
        mem_size         = byte_op ? MSZ_BYTE : MSZ_WORD;
      end
      ST_WB: begin
        reg_write_enable = 1'b1;
        reg_dst          = (cls == CL_R);
        mem_to_reg       = (cls == CL_LOAD);
      end
      ST_TRAP: trap = 1'b1;
      default: trap = 1'b1;
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] ret_q;
  logic [CNT_W-1:0] ret_d;

  assign ret_d = ret_q + {{(CNT_W-1){1'b0}}, retire};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_q <= '0;
    end else begin
      ret_q <= ret_d;
    end
  end

  assign retired = ret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign retired       = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized self-checking bench for mc_sequencer against a
// transaction-level model of the instruction phases.
module tb_mc_sequencer;
  import mips_pkg::*;

  localparam int TO = 15;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          imem_ready;
  logic          dmem_ready;
  logic          alu_branch;
  logic          alu_jump;
  logic          pc_we;
  logic          ir_we;
  logic          reg_write_enable;
  logic          mem_read_enable;
  logic          mem_write_enable;
  logic          alu_src;
  logic          mem_to_reg;
  logic          reg_dst;
  logic [1:0]    mem_size;
  logic [5:0]    alu_func;
  logic [1:0]    pc_src;
  logic          trap;
  logic [CW-1:0] retired;
  logic [18:0]   obs;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [CW-1:0] exp_ret = '0;

  mc_sequencer #(
    .MEM_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode          (opcode),
    .funct           (funct),
    .imem_ready      (imem_ready),
    .dmem_ready      (dmem_ready),
    .alu_branch      (alu_branch),
    .alu_jump        (alu_jump),
    .pc_we           (pc_we),
    .ir_we           (ir_we),
    .reg_write_enable(reg_write_enable),
    .mem_read_enable (mem_read_enable),
    .mem_write_enable(mem_write_enable),
    .alu_src         (alu_src),
    .mem_to_reg      (mem_to_reg),
    .reg_dst         (reg_dst),
    .mem_size        (mem_size),
    .alu_func        (alu_func),
    .pc_src          (pc_src),
    .trap            (trap),
    .retired         (retired)
  );

  always #5 clk = ~clk;

  assign obs = {pc_we, ir_we, reg_write_enable,
                mem_read_enable, mem_write_enable,
                alu_src, mem_to_reg, reg_dst,
                mem_size, alu_func, pc_src, trap};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] mk(
    input bit pcw, input bit irw, input bit rwe,
    input bit mre, input bit mwe, input bit asrc,
    input bit m2r, input bit rdst,
    input logic [1:0] msz, input logic [5:0] af,
    input logic [1:0] psrc, input bit tr);
    return {pcw, irw, rwe, mre, mwe, asrc, m2r, rdst,
            msz, af, psrc, tr};
  endfunction

  function automatic logic [18:0] idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0,
              2'b11, 6'h20, 2'b00, 0);
  endfunction

  function automatic logic [18:0] trapv();
    return mk(0, 0, 0, 0, 0, 0, 0, 0,
              2'b11, 6'h20, 2'b00, 1);
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic bit supported(input logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h09, 6'h20, 6'h23,
                      6'h28, 6'h2B, 6'h04, 6'h05, 6'h02};
  endfunction

  task automatic retire_one();
`ifdef SEQ_PERF_CNT_EN
    exp_ret = exp_ret + 1'b1;
`endif
  endtask

  task automatic cyc(input string tag, input bit ir,
                     input bit dr, input bit br,
                     input logic [18:0] exp);
    imem_ready = ir;
    dmem_ready = dr;
    alu_branch = br;
    alu_jump   = rb();
    #1;
    check(tag, {13'b0, obs}, {13'b0, exp});
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #1;
    check("reset_outs", {13'b0, obs}, {13'b0, idle()});
    check("reset_ret", 32'(retired), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    exp_ret = '0;
  endtask

  // One instruction from FETCH until it retires or traps.
  // iw/dw: not-ready cycles before imem/dmem ready.
  task automatic run_instr(input logic [5:0] op,
                           input logic [5:0] fn,
                           input int iw, input int dw,
                           input bit br, output bit trapped);
    bit is_r, is_imm, is_ld, is_st, is_br, is_j, is_b;
    logic [18:0] e;
    logic [18:0] m;
    is_r    = (op == 6'h00);
    is_imm  = op inside {6'h08, 6'h09};
    is_ld   = op inside {6'h20, 6'h23};
    is_st   = op inside {6'h28, 6'h2B};
    is_br   = op inside {6'h04, 6'h05};
    is_j    = (op == 6'h02);
    is_b    = op inside {6'h20, 6'h28};
    trapped = 1'b0;
    opcode  = op;
    funct   = fn;
    check("retired", 32'(retired), 32'(exp_ret));
    if (iw >= TO) begin
      repeat (TO) cyc("fetch_wait", 0, rb(), rb(), idle());
      repeat (3) cyc("fetch_to", rb(), rb(), rb(), trapv());
      trapped = 1'b1;
      return;
    end
    repeat (iw) cyc("fetch_wait", 0, rb(), rb(), idle());
    cyc("fetch", 1, rb(), rb(),
        mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b11, 6'h20, 2'b00, 0));
    cyc("decode", rb(), rb(), rb(), idle());
    opcode = 6'($urandom);
    funct  = 6'($urandom);
    if (!supported(op)) begin
      repeat (4) cyc("bad_op", rb(), rb(), rb(), trapv());
      trapped = 1'b1;
      return;
    end
    e = idle();
    if (is_r) begin
      e = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, fn, 2'b00, 0);
    end else if (is_imm || is_ld || is_st) begin
      e = mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b11, 6'h20, 2'b00, 0);
    end else if (is_br) begin
      e = mk(br, 0, 0, 0, 0, 0, 0, 0, 2'b11,
             (op == 6'h04) ? ALU_BEQ : ALU_BNE, 2'b01, 0);
    end else if (is_j) begin
      e = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 6'h20, 2'b10, 0);
    end
    cyc("execute", rb(), rb(), br, e);
    if (is_br || is_j) begin
      retire_one();
      return;
    end
    if (is_ld || is_st) begin
      m = mk(0, 0, 0, is_ld, is_st, 0, 0, 0,
             is_b ? 2'b00 : 2'b11, 6'h20, 2'b00, 0);
      if (dw >= TO) begin
        repeat (TO) cyc("mem_wait", rb(), 0, rb(), m);
        repeat (3) cyc("mem_to", rb(), rb(), rb(), trapv());
        trapped = 1'b1;
        return;
      end
      repeat (dw) cyc("mem_wait", rb(), 0, rb(), m);
      cyc("mem", rb(), 1, rb(), m);
      if (is_st) begin
        retire_one();
        return;
      end
    end
    cyc("wb", rb(), rb(), rb(),
        mk(0, 0, 1, 0, 0, 0, is_ld, is_r,
           2'b11, 6'h20, 2'b00, 0));
    retire_one();
  endtask

  logic [5:0] ops [10] = '{6'h00, 6'h08, 6'h09, 6'h20, 6'h23,
                           6'h28, 6'h2B, 6'h04, 6'h05, 6'h02};

  initial begin
    bit         tr;
    logic [5:0] op;
    int         iw;
    int         dw;
    reset      = 1'b1;
    opcode     = '0;
    funct      = '0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    alu_branch = 1'b0;
    alu_jump   = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed: add, lw with 3 wait cycles, beq taken/not, bad op.
    run_instr(6'h00, 6'h20, 0, 0, 0, tr);
    run_instr(6'h23, 6'h00, 0, 3, 0, tr);
    run_instr(6'h04, 6'h00, 0, 0, 1, tr);
    run_instr(6'h04, 6'h00, 0, 0, 0, tr);
    run_instr(6'h28, 6'h00, 2, 1, 0, tr);
    run_instr(6'h3F, 6'h00, 0, 0, 0, tr);
    do_reset();
    run_instr(6'h2B, 6'h00, 0, TO, 0, tr);
    do_reset();
    run_instr(6'h08, 6'h00, TO, 0, 0, tr);
    do_reset();

    // Async reset in the middle of a load's memory phase.
    run_instr(6'h00, 6'h24, 0, 0, 0, tr);
    opcode = 6'h23;
    cyc("a_fetch", 1, 0, 0,
        mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b11, 6'h20, 2'b00, 0));
    cyc("a_decode", 0, 0, 0, idle());
    cyc("a_exec", 0, 0, 0,
        mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b11, 6'h20, 2'b00, 0));
    cyc("a_mem", 1, 0, 0,
        mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b11, 6'h20, 2'b00, 0));
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst", {13'b0, obs}, {13'b0, idle()});
    check("async_ret", 32'(retired), 32'd0);
    @(negedge clk);
    do_reset();

    // Randomized instruction stream.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom); while (supported(op));
      end else begin
        op = ops[$urandom_range(0, 9)];
      end
      iw = ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, 3);
      dw = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, 4);
      run_instr(op, 6'($urandom), iw, dw, rb(), tr);
      if (tr) do_reset();
    end

    // Counter wrap: 257 addi on an 8-bit counter.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      run_instr(6'h08, 6'($urandom), 0, 0, 0, tr);
    end
`ifdef SEQ_PERF_CNT_EN
    check("retired_257", 32'(retired), 32'd1);
`else
    check("retired_257", 32'(retired), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
